// File: rtl/o_result_packer.sv
// o_result_packer
//   Packs the column (south) and row (east) byte streams from the output FIFO
//   stage into little-endian 32-bit words. Each word goes through one shared RAM
//   write port, and each stream writes into its own address region. One tile
//   runs per i_start. o_done pulses once every byte of the tile has been written.
//
//   Ports
//     i_clk, i_rst               clock, synchronous active-high reset
//     i_start                    start a tile (honoured in IDLE only)
//     i_col_base, i_row_base     first word address of each region (latched at start)
//     i_col_data/_valid          column byte stream, no backpressure
//     i_row_data/_valid          row byte stream, no backpressure
//     o_wr_en/_addr/_data        RAM write port; addr/data are 0 when not writing
//     o_busy                     tile in progress
//     o_done                     one-cycle completion pulse
//     o_err_unexp                sticky: a byte arrived outside RUN or past its count
//
// o_result_packer_stream
//   Per-stream packer. Holds the byte counter, the partial word and a 2-entry
//   queue of completed words. The queue covers the case where the port is busy
//   with the other stream, and the case where the stream finishes two words
//   back-to-back (a full word followed immediately by a final partial word).

module o_result_packer_stream #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 8,
  parameter int BYTES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [W_ADDR-1:0] base,
  input  logic              valid,
  input  logic [W_DATA-1:0] data,
  input  logic              grant,
  output logic              has,
  output logic [W_ADDR-1:0] head_addr,
  output logic [31:0]       head_word,
  output logic              complete,
  output logic              unexp
);
  localparam int CW = $clog2(BYTES + 4);
  localparam int EW = W_ADDR + 32;

  logic [CW-1:0]       byte_cnt;
  logic [W_ADDR-1:0]   word_n;
  logic [31:0]         partial;
  logic [1:0][EW-1:0]  q;
  logic [1:0]          q_cnt;

  logic                full, accept, last;
  logic [1:0]          lane;
  logic [31:0]         merged;
  logic [EW-1:0]       new_e;

  assign full   = (byte_cnt == CW'(BYTES));
  assign accept = run && valid && !full;
  assign unexp  = valid && !accept;
  assign lane   = byte_cnt[1:0];
  assign merged = partial | (32'(data) << {lane, 3'b000});
  assign last   = accept && (lane == 2'd3 || byte_cnt == CW'(BYTES - 1));
  assign new_e  = {base + word_n, merged};

  // A freshly completed word bypasses the queue when the queue is empty, so the
  // word reaches the port one cycle after completion.
  assign has                    = (q_cnt != 2'd0) || last;
  assign {head_addr, head_word} = (q_cnt != 2'd0) ? q[0] : new_e;
  assign complete               = full && (q_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      word_n   <= '0;
      partial  <= '0;
      q        <= '0;
      q_cnt    <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (last) begin
          partial <= '0;
          word_n  <= word_n + 1'b1;
        end else begin
          partial <= merged;
        end
      end
      case ({last, grant})
        2'b10: begin
          if (q_cnt == 2'd0) q[0] <= new_e;
          else               q[1] <= new_e;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b11: begin
          // The head is consumed and the new word takes its place at the tail.
          if (q_cnt == 2'd1) q[0] <= new_e;
          else if (q_cnt == 2'd2) begin
            q[0] <= q[1];
            q[1] <= new_e;
          end
        end
        2'b01: begin
          q[0]  <= q[1];
          q_cnt <= q_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

module o_result_packer #(
  parameter int W_DATA    = 8,
  parameter int W_ADDR    = 8,
  parameter int COL_BYTES = 3,
  parameter int ROW_BYTES = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [W_ADDR-1:0] i_col_base,
  input  logic [W_ADDR-1:0] i_row_base,
  input  logic [W_DATA-1:0] i_col_data,
  input  logic              i_col_valid,
  input  logic [W_DATA-1:0] i_row_data,
  input  logic              i_row_valid,
  output logic              o_wr_en,
  output logic [W_ADDR-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_unexp
);
  // Stream 0 is the column stream and has port priority. Stream 1 is the row stream.
  localparam int NUM_STREAMS = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [NUM_STREAMS-1:0][W_ADDR-1:0] base_q;
  logic [NUM_STREAMS-1:0][W_DATA-1:0] s_data;
  logic [NUM_STREAMS-1:0]             s_valid, s_has, s_grant, s_complete, s_unexp;
  logic [NUM_STREAMS-1:0][W_ADDR-1:0] s_addr;
  logic [NUM_STREAMS-1:0][31:0]       s_word;
  logic                               clear, run;

  assign s_data  = {i_row_data, i_col_data};
  assign s_valid = {i_row_valid, i_col_valid};
  assign clear   = (state == IDLE) && i_start;
  assign run     = (state == RUN);

  always_comb begin
    s_grant    = '0;
    s_grant[0] = s_has[0];
    s_grant[1] = s_has[1] && !s_has[0];
  end

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
    localparam int BYTES = (g == 0) ? COL_BYTES : ROW_BYTES;
    o_result_packer_stream #(
      .W_DATA(W_DATA), .W_ADDR(W_ADDR), .BYTES(BYTES)
    ) u_stream (
      .clk      (i_clk),
      .rst      (i_rst),
      .clear    (clear),
      .run      (run),
      .base     (base_q[g]),
      .valid    (s_valid[g]),
      .data     (s_data[g]),
      .grant    (s_grant[g]),
      .has      (s_has[g]),
      .head_addr(s_addr[g]),
      .head_word(s_word[g]),
      .complete (s_complete[g]),
      .unexp    (s_unexp[g])
    );
  end

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      base_q      <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_err_unexp <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state  <= RUN;
          base_q <= {i_row_base, i_col_base};
        end
        // complete means the count is reached and nothing is queued. The last
        // write is then on the port this cycle, so DONE lands right after it.
        RUN:  if (&s_complete) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      o_wr_en   <= |s_grant;
      o_wr_addr <= s_grant[0] ? s_addr[0] : (s_grant[1] ? s_addr[1] : '0);
      o_wr_data <= s_grant[0] ? s_word[0] : (s_grant[1] ? s_word[1] : '0);

      // A new error in the same cycle as i_start still registers.
      o_err_unexp <= (o_err_unexp && !i_start) || (|s_unexp);
    end
  end
endmodule
